twiddle_gen_param: RTL

// Parametrised twiddle generator for radix-2 DIT FFT of size N = 2**LOG2N.
// On start, streams W^k for butterflies b = 0..N/2-1 of one stage, k = (b & (2^s-1)) << (LOG2N-1-s).

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/twiddle_qtr_rom.sv | 33 +++
 rtl/twiddle_gen_param.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT twiddle path: sizing defaults, FSM encoding,
// quarter-wave cosine table generator and twiddle packing helpers.
package fft_pkg;

    localparam int  LOG2N_DEF = 8;
    localparam int  TW_W_DEF  = 12;
    localparam real PI        = 3.14159265358979323846;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Entry m of the quarter-wave table; all entries are >= 0 so +0.5 rounds to nearest.
    function automatic int cos_entry(input int m, input int log2n, input int tw_w);
        real amp;
        real ang;
        amp = real'((1 << (tw_w - 1)) - 1);
        ang = 2.0 * PI * real'(m) / real'(1 << log2n);
        return $rtoi($cos(ang) * amp + 0.5);
    endfunction

    function automatic logic [63:0] pack_tw(input logic [31:0] re, input logic [31:0] im);
        return {im, re};
    endfunction

    function automatic void unpack_tw(input logic [63:0] tw, output logic [31:0] re,
                                      output logic [31:0] im);
        re = tw[31:0];
        im = tw[63:32];
    endfunction

endpackage

// File: rtl/twiddle_qtr_rom.sv
// Quarter-wave cosine table (N/4+1 entries) with two registered read ports.
// Contents are fixed at elaboration from cos_entry; no memory file is needed.
module twiddle_qtr_rom
    import fft_pkg::*;
#(
    parameter  int LOG2N = LOG2N_DEF,
    parameter  int TW_W  = TW_W_DEF,
    localparam int AW    = LOG2N - 1,
    localparam int DEPTH = (1 << (LOG2N - 2)) + 1
) (
    input  logic            clk,
    input  logic            en,
    input  logic [AW-1:0]   addr_a,
    input  logic [AW-1:0]   addr_b,
    output logic [TW_W-1:0] data_a,
    output logic [TW_W-1:0] data_b
);

    logic [TW_W-1:0] cos_tab [DEPTH];

    for (genvar m = 0; m < DEPTH; m++) begin : g_entry
        localparam int VAL = cos_entry(m, LOG2N, TW_W);
        assign cos_tab[m] = TW_W'(VAL);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= cos_tab[addr_a];
            data_b <= cos_tab[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_gen_param.sv
// Radix-2 DIT twiddle streamer: FSM + butterfly counter, k/quadrant select,
// registered quarter-table read, mirror/negate stage, valid/ready output.
module twiddle_gen_param
    import fft_pkg::*;
#(
    parameter  int LOG2N = LOG2N_DEF,
    parameter  int TW_W  = TW_W_DEF,
    // Stage port is one value wider than needed so LOG2N itself can arrive and be rejected.
    localparam int SW    = clog2(LOG2N + 1),
    localparam int KW    = LOG2N - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SW-1:0]          stage,
    input  logic                   inverse,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [TW_W-1:0] tw_real,
    output logic signed [TW_W-1:0] tw_imag,
    output logic [KW-1:0]          tw_k,
    output logic [KW-1:0]          tw_bfly
);

    localparam logic [KW-1:0] QTR    = KW'(1 << (LOG2N - 2));
    localparam logic [KW-1:0] LAST_B = '1;

    state_t        state;
    logic [SW-1:0] stage_q;
    logic          inv_q;
    logic [KW-1:0] b_cnt;

    logic          pipe_en;
    logic          issue;
    logic          accept;

    logic [KW-1:0] k_mask;
    logic [KW-1:0] k_next;
    logic [KW-1:0] j_next;
    logic [KW-1:0] addr_re_n;
    logic [KW-1:0] addr_sin_n;
    logic          neg_re_n;

    logic          v1;
    logic          neg1;
    logic [KW-1:0] k1;
    logic [KW-1:0] b1;
    logic [KW-1:0] addr_re1;
    logic [KW-1:0] addr_sin1;

    logic          v2;
    logic          neg2;
    logic [KW-1:0] k2;
    logic [KW-1:0] b2;

    logic signed [TW_W-1:0] rom_re;
    logic signed [TW_W-1:0] rom_sin;

    assign pipe_en = !out_valid || out_ready;
    assign issue   = (state == RUN) && pipe_en;
    assign accept  = out_valid && out_ready;

    // k keeps the low s bits of b and scales them up to the N-point exponent.
    always_comb begin
        k_mask     = '1;
        k_mask     = k_mask >> (KW - int'(stage_q));
        k_next     = (b_cnt & k_mask) << (KW - int'(stage_q));
        j_next     = k_next - QTR;
        addr_re_n  = k_next;
        addr_sin_n = QTR - k_next;
        neg_re_n   = 1'b0;
        if (k_next > QTR) begin
            addr_re_n  = QTR - j_next;
            addr_sin_n = j_next;
            neg_re_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            stage_q <= '0;
            inv_q   <= 1'b0;
            b_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (int'(stage) < LOG2N) begin
                            state   <= RUN;
                            stage_q <= stage;
                            inv_q   <= inverse;
                            b_cnt   <= '0;
                            busy    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        b_cnt <= b_cnt + KW'(1);
                        if (b_cnt == LAST_B) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept && tw_bfly == LAST_B) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    twiddle_qtr_rom #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_rom (
        .clk    (clk),
        .en     (pipe_en),
        .addr_a (addr_re1),
        .addr_b (addr_sin1),
        .data_a (rom_re),
        .data_b (rom_sin)
    );

    // One shared enable moves every stage, so a stall freezes the whole pipe in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            neg1      <= 1'b0;
            k1        <= '0;
            b1        <= '0;
            addr_re1  <= '0;
            addr_sin1 <= '0;
            v2        <= 1'b0;
            neg2      <= 1'b0;
            k2        <= '0;
            b2        <= '0;
            out_valid <= 1'b0;
            tw_real   <= '0;
            tw_imag   <= '0;
            tw_k      <= '0;
            tw_bfly   <= '0;
        end else if (pipe_en) begin
            v1        <= issue;
            neg1      <= neg_re_n;
            k1        <= k_next;
            b1        <= b_cnt;
            addr_re1  <= addr_re_n;
            addr_sin1 <= addr_sin_n;
            v2        <= v1;
            neg2      <= neg1;
            k2        <= k1;
            b2        <= b1;
            out_valid <= v2;
            if (v2) begin
                tw_real <= neg2 ? -rom_re : rom_re;
                tw_imag <= inv_q ? rom_sin : -rom_sin;
                tw_k    <= k2;
                tw_bfly <= b2;
            end
        end
    end

endmodule
